// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the fft_peak_sched controller.
// FFT_PEAK_CONT_EN selects free-running (continuous) scheduling.
package fft_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        SCAN,
        DRAIN,
        REPORT
    } state_t;

    localparam int BIN_W_DEF = 8;
    localparam int MAG_W_DEF = 16;

    function automatic int half_bins(input int n);
        return n / 2 - 1;
    endfunction

endpackage

// File: rtl/fft_peak_track.sv
// Running-maximum tracker: keeps the first bin holding the largest magnitude.
import fft_sched_pkg::*;

module fft_peak_track #(
    parameter int BIN_W = BIN_W_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [BIN_W-1:0] i_bin,
    input  logic [MAG_W-1:0] i_mag,
    output logic [BIN_W-1:0] o_bin,
    output logic [MAG_W-1:0] o_mag
);

    logic [BIN_W-1:0] r_bin;
    logic [MAG_W-1:0] r_mag;

    // Strict compare: bins arrive in ascending order, so ties keep the lower one.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_bin <= '0;
            r_mag <= '0;
        end else if (i_valid && (i_mag > r_mag)) begin
            r_bin <= i_bin;
            r_mag <= i_mag;
        end
    end

    assign o_bin = r_bin;
    assign o_mag = r_mag;

endmodule

// File: rtl/fft_peak_sched.sv
// Sequences fft_sm: start, wait for Done, scan bins, report the peak bin.
// Define FFT_PEAK_CONT_EN for free-running restart after each report.
import fft_sched_pkg::*;

module fft_peak_sched #(
    parameter int N_BINS      = 256,
    parameter int BIN_W       = BIN_W_DEF,
    parameter int MAG_W       = MAG_W_DEF,
    parameter int RESULT_LAT  = 1,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             CoreReady,
    input  logic             CoreDone,
    input  logic             CoreOverflow,
    input  logic [MAG_W-1:0] CoreResult,
    output logic             CoreStart,
    output logic [BIN_W-1:0] CoreInspect,
    output logic [BIN_W-1:0] PeakBin,
    output logic [MAG_W-1:0] PeakMag,
    output logic             PeakValid,
    output logic             Busy,
    output logic             Overflow,
    output logic             Error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(half_bins(N_BINS));
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] DR_LAST  = CNT_W'(RESULT_LAT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0] r_inspect;
    logic [BIN_W-1:0] r_peak_bin;
    logic [MAG_W-1:0] r_peak_mag;
    logic             r_peak_valid;
    logic             r_ovf;
    logic             r_err;
    logic [BIN_W-1:0] r_dl_idx [RESULT_LAT];
    logic             r_dl_vld [RESULT_LAT];
    logic [BIN_W-1:0] w_max_bin;
    logic [MAG_W-1:0] w_max_mag;
    logic             w_accept;
    logic             w_restart;
    logic             w_done_ok;
    logic             w_timeout;
    logic             w_cnt_run;

    assign w_accept  = (r_state == IDLE) && Go && CoreReady;
    // A Done level left over from the previous run is ignored on the first wait cycle.
    assign w_done_ok = CoreDone && (r_cnt != '0);
    assign w_timeout = (r_cnt == TO_LAST);
    assign w_cnt_run = ((r_state == WAIT_DONE) || (r_state == DRAIN))
                       && (w_next == r_state);

`ifdef FFT_PEAK_CONT_EN
    logic r_cont;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cont <= 1'b0;
        end else if (w_accept) begin
            r_cont <= 1'b1;
        end else if (Go || ((r_state == WAIT_DONE) && !w_done_ok && w_timeout)) begin
            r_cont <= 1'b0;
        end
    end

    assign w_restart = r_cont && CoreReady && !Go;
`else
    assign w_restart = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (w_accept || w_restart) w_next = START;
            START:     w_next = WAIT_DONE;
            WAIT_DONE: begin
                if (w_done_ok)      w_next = SCAN;
                else if (w_timeout) w_next = IDLE;
            end
            SCAN:      if (r_inspect == LAST_BIN) w_next = DRAIN;
            DRAIN:     if (r_cnt == DR_LAST) w_next = REPORT;
            REPORT:    w_next = w_restart ? START : IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_inspect    <= '0;
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
            r_peak_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_run ? r_cnt + CNT_W'(1) : '0;
            r_peak_valid <= (r_state == REPORT);
            if ((r_state == WAIT_DONE) && w_done_ok) begin
                r_inspect <= BIN_W'(1);
            end else if ((r_state == SCAN) && (r_inspect != LAST_BIN)) begin
                r_inspect <= r_inspect + BIN_W'(1);
            end
            if (r_state == REPORT) begin
                r_peak_bin <= w_max_bin;
                r_peak_mag <= w_max_mag;
            end
            if (w_accept) begin
                r_ovf <= 1'b0;
                r_err <= 1'b0;
            end else begin
                if ((r_state != IDLE) && CoreOverflow) r_ovf <= 1'b1;
                if ((r_state == WAIT_DONE) && !w_done_ok && w_timeout) r_err <= 1'b1;
            end
        end
    end

    // Bin index and valid ride alongside the core's readback latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < RESULT_LAT; k++) begin
                r_dl_idx[k] <= '0;
                r_dl_vld[k] <= 1'b0;
            end
        end else begin
            r_dl_idx[0] <= r_inspect;
            r_dl_vld[0] <= (r_state == SCAN);
            for (int k = 1; k < RESULT_LAT; k++) begin
                r_dl_idx[k] <= r_dl_idx[k-1];
                r_dl_vld[k] <= r_dl_vld[k-1];
            end
        end
    end

    fft_peak_track #(
        .BIN_W (BIN_W),
        .MAG_W (MAG_W)
    ) u_track (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_clear ((r_state == WAIT_DONE) && w_done_ok),
        .i_valid (r_dl_vld[RESULT_LAT-1]),
        .i_bin   (r_dl_idx[RESULT_LAT-1]),
        .i_mag   (CoreResult),
        .o_bin   (w_max_bin),
        .o_mag   (w_max_mag)
    );

    assign CoreStart   = (r_state == START);
    assign Busy        = (r_state != IDLE);
    assign CoreInspect = r_inspect;
    assign PeakBin     = r_peak_bin;
    assign PeakMag     = r_peak_mag;
    assign PeakValid   = r_peak_valid;
    assign Overflow    = r_ovf;
    assign Error       = r_err;

endmodule

// File: tb/tb_fft_peak_sched.sv
// Randomized bench for fft_peak_sched: two instances (readback latency 1 and 3)
// share control stimulus and are checked against an argmax reference.
module tb_fft_peak_sched;

    localparam int NB   = 16;
    localparam int HALF = NB / 2 - 1;
    localparam int LA   = 1;
    localparam int LB   = 3;
    localparam int TO   = 64;

    logic clk = 1'b0;
    logic rst, go, rdy, done, ovf;
    logic [15:0] res_a, res_b;
    logic a_start, a_busy, a_pv, a_ovf, a_err;
    logic b_start, b_busy, b_pv, b_ovf, b_err;
    logic [7:0] a_insp, a_bin, b_insp, b_bin;
    logic [15:0] a_mag, b_mag;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int a_st_n = 0, b_st_n = 0, a_pv_n = 0, b_pv_n = 0;
    int a_st_cyc = 0, a_pv_cyc = 0, b_pv_cyc = 0;
    logic [7:0] last_b = 8'd0;
    logic [15:0] last_m = 16'd0;

    logic [15:0] spec [NB];
    logic [7:0] ha;
    logic [7:0] hb [LB];

    always #5 clk = ~clk;

    fft_peak_sched #(
        .N_BINS(NB), .BIN_W(8), .MAG_W(16), .RESULT_LAT(LA), .TIMEOUT_CYC(TO)
    ) u_dut_a (
        .Clk(clk), .Reset(rst), .Go(go), .CoreReady(rdy), .CoreDone(done),
        .CoreOverflow(ovf), .CoreResult(res_a), .CoreStart(a_start),
        .CoreInspect(a_insp), .PeakBin(a_bin), .PeakMag(a_mag),
        .PeakValid(a_pv), .Busy(a_busy), .Overflow(a_ovf), .Error(a_err)
    );

    fft_peak_sched #(
        .N_BINS(NB), .BIN_W(8), .MAG_W(16), .RESULT_LAT(LB), .TIMEOUT_CYC(TO)
    ) u_dut_b (
        .Clk(clk), .Reset(rst), .Go(go), .CoreReady(rdy), .CoreDone(done),
        .CoreOverflow(ovf), .CoreResult(res_b), .CoreStart(b_start),
        .CoreInspect(b_insp), .PeakBin(b_bin), .PeakMag(b_mag),
        .PeakValid(b_pv), .Busy(b_busy), .Overflow(b_ovf), .Error(b_err)
    );

    // Core readback model: result follows Inspect by the configured latency.
    always @(posedge clk) begin
        ha    <= a_insp;
        hb[0] <= b_insp;
        hb[1] <= hb[0];
        hb[2] <= hb[1];
    end
    assign res_a = spec[ha[3:0]];
    assign res_b = spec[hb[LB-1][3:0]];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (a_start) begin a_st_n++; a_st_cyc = cyc; end
        if (b_start) b_st_n++;
        if (a_pv) begin a_pv_n++; a_pv_cyc = cyc; end
        if (b_pv) begin b_pv_n++; b_pv_cyc = cyc; end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic ref_peak(output logic [7:0] eb, output logic [15:0] em);
        eb = 8'd0;
        em = 16'd0;
        for (int k = 1; k <= HALF; k++) begin
            if (spec[k] > em) begin
                em = spec[k];
                eb = 8'(k);
            end
        end
    endtask

    task automatic set_bg();
        spec[0] = 16'hFFFF;
        for (int k = HALF + 1; k < NB; k++) spec[k] = 16'hFFFF;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, {a_start, a_busy, a_pv, a_ovf, a_err, a_insp, a_bin, a_mag}, 64'd0);
        chk({tag, "_b"}, {b_start, b_busy, b_pv, b_ovf, b_err, b_insp, b_bin, b_mag}, 64'd0);
    endtask

    task automatic do_run(input string tag, input bit stale, input bit inj);
        int pa0, pb0, sa0, sb0, dcyc;
        logic [7:0] eb;
        logic [15:0] em;
        pa0 = a_pv_n; pb0 = b_pv_n; sa0 = a_st_n; sb0 = b_st_n;
        if (stale) done = 1'b1;
        pulse_go();
        for (int i = 0; i < 8 && a_st_n == sa0; i++) tick();
        chk({tag, "_clr"}, {a_ovf, a_err, b_ovf, b_err}, 64'd0);
        if (stale) begin
            // START, one ignored wait cycle, then Done sampled at the next edge
            dcyc = a_st_cyc + 3;
        end else begin
            repeat ($urandom_range(1, 5)) tick();
            if (inj) begin
                ovf = 1'b1;
                go  = 1'b1;
                tick();
                ovf = 1'b0;
                go  = 1'b0;
            end
            done = 1'b1;
            dcyc = cyc + 1;
        end
        for (int i = 0; i < 60 && !(a_pv_n > pa0 && b_pv_n > pb0); i++) begin
            go = (i == 2);
            tick();
        end
        go   = 1'b0;
        done = 1'b0;
        repeat (4) tick();
        ref_peak(eb, em);
        last_b = eb;
        last_m = em;
        chk({tag, "_a_bin"}, a_bin, eb);
        chk({tag, "_a_mag"}, a_mag, em);
        chk({tag, "_b_bin"}, b_bin, eb);
        chk({tag, "_b_mag"}, b_mag, em);
        chk({tag, "_a_lat"}, a_pv_cyc - dcyc, HALF + LA + 1);
        chk({tag, "_b_lat"}, b_pv_cyc - dcyc, HALF + LB + 1);
        chk({tag, "_pulses"}, {a_pv_n - pa0, b_pv_n - pb0}, {32'd1, 32'd1});
        chk({tag, "_starts"}, {a_st_n - sa0, b_st_n - sb0}, {32'd1, 32'd1});
        chk({tag, "_flags"}, {a_ovf, a_err, b_ovf, b_err, a_busy, b_busy},
            {inj, 1'b0, inj, 1'b0, 1'b0, 1'b0});
        chk({tag, "_insp"}, {a_insp, b_insp}, {8'(HALF), 8'(HALF)});
    endtask

    initial begin
        int sa0, pa0, pb0, s0, ecyc;
        rst = 1'b1; go = 1'b0; rdy = 1'b1; done = 1'b0; ovf = 1'b0;
        for (int k = 0; k < NB; k++) spec[k] = 16'd0;
        repeat (3) tick();
        chk_zero("rst_hold");
        rst = 1'b0;
        tick();
        chk_zero("rst_rel");

        set_bg();
        for (int k = 1; k <= HALF; k++) spec[k] = 16'(3 * k);
        do_run("ramp", 1'b0, 1'b1);

        for (int k = 1; k <= HALF; k++) spec[k] = 16'($urandom_range(0, 499));
        spec[3] = 16'd500;
        spec[5] = 16'd500;
        do_run("tie", 1'b0, 1'b0);

        for (int k = 1; k <= HALF; k++) spec[k] = 16'd0;
        spec[4] = 16'h1234;
        do_run("spike", 1'b0, 1'b0);

        for (int k = 1; k <= HALF; k++) spec[k] = 16'd0;
        do_run("zero", 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 1; k <= HALF; k++)
                spec[k] = 16'($urandom_range(0, (r < 2) ? 7 : 65535));
            do_run($sformatf("rnd%0d", r), 1'b0, 1'b0);
        end

        for (int k = 1; k <= HALF; k++) spec[k] = 16'($urandom_range(0, 65535));
        do_run("stale", 1'b1, 1'b0);

        // WAIT_DONE timeout with Done never asserted
        sa0 = a_st_n; pa0 = a_pv_n; pb0 = b_pv_n;
        pulse_go();
        for (int i = 0; i < 8 && a_st_n == sa0; i++) tick();
        s0 = a_st_cyc;
        ecyc = 0;
        for (int i = 0; i < 100 && !a_err; i++) begin
            tick();
            if (a_err) ecyc = cyc;
        end
        chk("to_lat", ecyc - s0, TO + 1);
        chk("to_flags", {a_err, b_err, a_busy, b_busy}, {1'b1, 1'b1, 1'b0, 1'b0});
        chk("to_peak_a", {a_bin, a_mag}, {last_b, last_m});
        chk("to_peak_b", {b_bin, b_mag}, {last_b, last_m});
        chk("to_nopv", {a_pv_n - pa0, b_pv_n - pb0}, 64'd0);

        // Go while the core is not ready is dropped, not queued
        sa0 = a_st_n;
        rdy = 1'b0;
        pulse_go();
        repeat (3) tick();
        rdy = 1'b1;
        repeat (5) tick();
        chk("nordy", {a_st_n - sa0, 31'd0, a_busy}, 64'd0);

        for (int k = 1; k <= HALF; k++) spec[k] = 16'($urandom_range(0, 65535));
        do_run("after_to", 1'b0, 1'b0);

        // Reset while scanning aborts the run
        sa0 = a_st_n; pa0 = a_pv_n; pb0 = b_pv_n;
        pulse_go();
        for (int i = 0; i < 8 && a_st_n == sa0; i++) tick();
        tick();
        done = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_zero("mid_rst");
        rst  = 1'b0;
        done = 1'b0;
        repeat (15) tick();
        chk("mid_rst_nopv", {a_pv_n - pa0, b_pv_n - pb0}, 64'd0);

`ifdef FFT_PEAK_CONT_EN
        sa0 = a_st_n;
        done = 1'b1;
        pulse_go();
        for (int i = 0; i < 80 && (a_st_n - sa0) < 3; i++) tick();
        chk("cont_starts", (a_st_n - sa0) >= 3, 1);
        pulse_go();
        done = 1'b0;
        repeat (60) tick();
        sa0 = a_st_n;
        repeat (20) tick();
        chk("cont_stop", {a_st_n - sa0, 31'd0, a_busy}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
